// File: rtl/cobalt_pkg.sv
// Shared constants for the CDB arbitration slice.
//   W_TAG   : tag width, equal to the tag free-list FIFO data width
//   W_DATA  : result width carried on the CDB
//   N_REQ   : number of completing execution units
//   unit_e  : requester index of each execution unit on the arbiter
package cobalt_pkg;

  localparam int unsigned W_TAG  = 6;
  localparam int unsigned W_DATA = 32;
  localparam int unsigned N_REQ  = 4;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2,
    UNIT_LS  = 2'd3
  } unit_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : search start index
//   grant_o : one-hot grant of the first request at or after ptr_i (wrapping), zero if none
//   idx_o   : encoded index of the granted request
//   found_o : any request present
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  logic [N-1:0]   lo_mask;
  logic [2*N-1:0] dbl;

  // Low half holds only requests at or after ptr_i; the unmasked upper
  // half supplies the wrapped-around candidates, so a single LSB-first
  // scan gives the round-robin winner.
  always_comb begin
    lo_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lo_mask[i] = (i < 32'(ptr_i));
    end
    dbl     = {req_i, req_i & ~lo_mask};
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < 2*N; i++) begin
      if (!found_o && dbl[i]) begin
        found_o = 1'b1;
        idx_o   = PW'(i % N);
      end
    end
    if (found_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the Common Data Bus to one completing unit per cycle
// and broadcasts its tag/result on a registered CDB.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   req_valid/tag/data   : per-unit completed result, held until granted
//   req_grant            : combinational one-hot accept (zero during reset)
//   cdb_valid/tag/data   : registered broadcast, one cycle after the grant
//   cdb_src              : index of the unit owning the current broadcast
//   starve               : sticky per-unit starvation flags
// FIXED_PRIO selects an absolute-priority unit; FIXED_PRIO == N_REQ disables it.
module cdb_arbiter #(
  parameter int unsigned N_REQ      = cobalt_pkg::N_REQ,
  parameter int unsigned W_TAG      = cobalt_pkg::W_TAG,
  parameter int unsigned W_DATA     = cobalt_pkg::W_DATA,
  parameter int unsigned FIXED_PRIO = 32'(cobalt_pkg::UNIT_MUL),
  parameter int unsigned STARVE_LIM = 15,
  localparam int unsigned PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*W_TAG-1:0]    req_tag,
  input  logic [N_REQ*W_DATA-1:0]   req_data,
  output logic [N_REQ-1:0]          req_grant,
  output logic                      cdb_valid,
  output logic [W_TAG-1:0]          cdb_tag,
  output logic [W_DATA-1:0]         cdb_data,
  output logic [PW-1:0]             cdb_src,
  output logic [N_REQ-1:0]          starve
);

  localparam bit            FP_EN    = (FIXED_PRIO < N_REQ);
  localparam int unsigned   FP_IDX   = FP_EN ? FIXED_PRIO : 0;
  localparam logic [PW-1:0] FP_IDX_W = PW'(FP_IDX);
  localparam logic [PW-1:0] LAST     = PW'(N_REQ - 1);

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  rr_grant;
  logic [PW-1:0]     rr_idx;
  logic              rr_found;
  logic              fixed_hit;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;

  logic              cdb_valid_q, cdb_valid_d;
  logic [W_TAG-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [W_DATA-1:0] cdb_data_q,  cdb_data_d;
  logic [PW-1:0]     cdb_src_q,   cdb_src_d;
  logic [3:0]        wait_q [N_REQ];
  logic [3:0]        wait_d [N_REQ];
  logic [N_REQ-1:0]  starve_q, starve_d;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  always_comb begin
    fixed_hit = FP_EN && req_valid[FP_IDX];
    req_grant = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    if (!reset) begin
      if (fixed_hit) begin
        req_grant[FP_IDX] = 1'b1;
        gnt_idx           = FP_IDX_W;
        gnt_any           = 1'b1;
      end else if (rr_found) begin
        req_grant = rr_grant;
        gnt_idx   = rr_idx;
        gnt_any   = 1'b1;
        rr_ptr_d  = (rr_idx == LAST) ? '0 : rr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    cdb_valid_d = gnt_any;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (gnt_any) begin
      cdb_tag_d  = req_tag[gnt_idx*W_TAG +: W_TAG];
      cdb_data_d = req_data[gnt_idx*W_DATA +: W_DATA];
      cdb_src_d  = gnt_idx;
    end
  end

  // Counters saturate at 15; the priority unit keeps its counter but never flags.
  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_grant[i] || !req_valid[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != 4'hF) begin
        wait_d[i] = wait_q[i] + 4'd1;
      end
      if (!(FP_EN && i == FP_IDX) && 32'(wait_d[i]) == STARVE_LIM) begin
        starve_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      starve_q    <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) wait_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      starve_q    <= starve_d;
      for (int unsigned i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign starve    = starve_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: three instances (priority disabled, priority on
// unit 1, priority on unit 0), each driven with its own stimulus and checked
// every cycle against a behavioural model of the arbitration rules.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int WT = 6;
  localparam int WD = 32;
  localparam int NI = 3;
  localparam int SL = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    rv  [NI];
  logic [N*WT-1:0] rt  [NI];
  logic [N*WD-1:0] rd  [NI];
  logic [N-1:0]    gnt [NI];
  logic            cv  [NI];
  logic [WT-1:0]   ct  [NI];
  logic [WD-1:0]   cdt [NI];
  logic [1:0]      cs  [NI];
  logic [N-1:0]    st  [NI];

  cdb_arbiter #(.N_REQ(N), .W_TAG(WT), .W_DATA(WD), .FIXED_PRIO(4), .STARVE_LIM(SL)) u_dut0 (
    .clk(clk), .reset(rst), .req_valid(rv[0]), .req_tag(rt[0]), .req_data(rd[0]),
    .req_grant(gnt[0]), .cdb_valid(cv[0]), .cdb_tag(ct[0]), .cdb_data(cdt[0]),
    .cdb_src(cs[0]), .starve(st[0]));
  cdb_arbiter #(.N_REQ(N), .W_TAG(WT), .W_DATA(WD), .FIXED_PRIO(1), .STARVE_LIM(SL)) u_dut1 (
    .clk(clk), .reset(rst), .req_valid(rv[1]), .req_tag(rt[1]), .req_data(rd[1]),
    .req_grant(gnt[1]), .cdb_valid(cv[1]), .cdb_tag(ct[1]), .cdb_data(cdt[1]),
    .cdb_src(cs[1]), .starve(st[1]));
  cdb_arbiter #(.N_REQ(N), .W_TAG(WT), .W_DATA(WD), .FIXED_PRIO(0), .STARVE_LIM(SL)) u_dut2 (
    .clk(clk), .reset(rst), .req_valid(rv[2]), .req_tag(rt[2]), .req_data(rd[2]),
    .req_grant(gnt[2]), .cdb_valid(cv[2]), .cdb_tag(ct[2]), .cdb_data(cdt[2]),
    .cdb_src(cs[2]), .starve(st[2]));

  int vecs = 0;
  int miss = 0;

  // Reference model state
  int            m_ptr [NI];
  int            m_cnt [NI][N];
  bit            m_stv [NI][N];
  bit            m_v   [NI];
  logic [WT-1:0] m_t   [NI];
  logic [WD-1:0] m_d   [NI];
  int            m_s   [NI];
  int            lg    [NI];

  function automatic int fpv(int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int pick(int k);
    int c;
    if (rst) return -1;
    if (fpv(k) < N) begin
      if (rv[k][fpv(k)]) return fpv(k);
    end
    for (int j = 0; j < N; j++) begin
      c = (m_ptr[k] + j) % N;
      if (rv[k][c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // One clock cycle: check grants before the edge, advance model, check registers after.
  task automatic step();
    int g [NI];
    logic [N-1:0] eg;
    logic [N-1:0] es;
    #1;
    for (int k = 0; k < NI; k++) begin
      g[k] = pick(k);
      eg = '0;
      if (g[k] >= 0) eg[g[k]] = 1'b1;
      chk("grant", k, 64'(gnt[k]), 64'(eg));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      lg[k] = g[k];
      if (rst) begin
        m_v[k] = 1'b0; m_t[k] = '0; m_d[k] = '0; m_s[k] = 0; m_ptr[k] = 0;
        for (int i = 0; i < N; i++) begin m_cnt[k][i] = 0; m_stv[k][i] = 1'b0; end
      end else begin
        m_v[k] = (g[k] >= 0);
        if (g[k] >= 0) begin
          m_t[k] = rt[k][g[k]*WT +: WT];
          m_d[k] = rd[k][g[k]*WD +: WD];
          m_s[k] = g[k];
          if (g[k] != fpv(k)) m_ptr[k] = (g[k] + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (g[k] == i || !rv[k][i]) m_cnt[k][i] = 0;
          else if (m_cnt[k][i] < 15) m_cnt[k][i]++;
          if (m_cnt[k][i] == SL && i != fpv(k)) m_stv[k][i] = 1'b1;
        end
      end
      es = '0;
      for (int i = 0; i < N; i++) es[i] = m_stv[k][i];
      chk("cdb_valid", k, 64'(cv[k]), 64'(m_v[k]));
      chk("cdb_tag", k, 64'(ct[k]), 64'(m_t[k]));
      chk("cdb_data", k, 64'(cdt[k]), 64'(m_d[k]));
      chk("cdb_src", k, 64'(cs[k]), 64'(m_s[k]));
      chk("starve", k, 64'(st[k]), 64'(es));
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rv[k] = '1;
      for (int i = 0; i < N; i++) begin
        rt[k][i*WT +: WT] = 6'($urandom);
        rd[k][i*WD +: WD] = $urandom;
      end
      lg[k] = -1;
    end

    // 1: reset with all requesting, then release idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) rv[k] = '0;
    step();
    chk("t1_valid_after_rst", 0, 64'(cv[0]), 64'(0));
    chk("t1_starve_after_rst", 2, 64'(st[2]), 64'(0));

    // 2: round robin with priority disabled, all four requesting
    for (int i = 0; i < N; i++) rt[0][i*WT +: WT] = 6'(i + 10);
    rv[0] = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("t2_src_seq", 0, 64'(cs[0]), 64'(j % 4));
      chk("t2_tag_seq", 0, 64'(ct[0]), 64'(j % 4 + 10));
    end
    rv[0] = '0;

    // 3: priority unit 1 streaming tags 5,6,7 ahead of unit 2
    rv[1] = 4'b0110;
    rt[1][2*WT +: WT] = 6'h22;
    for (int j = 0; j < 3; j++) begin
      rt[1][1*WT +: WT] = 6'(5 + j);
      step();
      chk("t3_tag_fixed", 1, 64'(ct[1]), 64'(5 + j));
    end
    rv[1] = 4'b0100;
    step();
    chk("t3_tag_rr", 1, 64'(ct[1]), 64'(6'h22));
    chk("t3_src_rr", 1, 64'(cs[1]), 64'(2));
    rv[1] = '0;

    // 4: lone requester 3 at the tag/data extremes
    rv[0] = 4'b1000;
    rt[0][3*WT +: WT] = 6'h3F;
    rd[0][3*WD +: WD] = 32'hDEADBEEF;
    #1;
    chk("t4_grant_same_cycle", 0, 64'(gnt[0]), 64'(4'b1000));
    step();
    chk("t4_valid", 0, 64'(cv[0]), 64'(1));
    chk("t4_tag", 0, 64'(ct[0]), 64'(6'h3F));
    chk("t4_data", 0, 64'(cdt[0]), 64'(32'hDEADBEEF));
    rv[0] = '0;

    // 5: unit 2 starved behind priority unit 0
    rv[2] = 4'b0101;
    for (int j = 0; j < 15; j++) begin
      step();
      if (j == 13) chk("t5_not_yet", 2, 64'(st[2]), 64'(0));
    end
    chk("t5_starve_set", 2, 64'(st[2]), 64'(4'b0100));
    rv[2] = 4'b0100;
    step();
    chk("t5_granted", 2, 64'(cs[2]), 64'(2));
    rv[2] = '0;
    step();
    chk("t5_sticky", 2, 64'(st[2]), 64'(4'b0100));

    // 6: reset mid-stream; pointer restarts at 0
    rv[0] = 4'b0110;
    step();
    rst = 1'b1;
    step();
    chk("t6_dropped", 0, 64'(cv[0]), 64'(0));
    rst = 1'b0;
    #1;
    chk("t6_first_grant", 0, 64'(gnt[0]), 64'(4'b0010));
    step();
    rv[0] = '0;
    step();

    // Random traffic; ungranted requests are held stable
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NI; k++) begin
        for (int i = 0; i < N; i++) begin
          if (!(rv[k][i] && lg[k] != i) || rst) begin
            rv[k][i] = ($urandom_range(0, 2) != 0);
            rt[k][i*WT +: WT] = 6'($urandom);
            rd[k][i*WD +: WD] = $urandom;
          end
        end
      end
      rst = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
